muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Multi-cycle RV32M multiply/divide unit beside the single-cycle execute ALU.
- The decoder routes funct7=0000001 OP instructions here. The unit stalls the pipe through a valid/ready handshake until the result is ready.
- XLEN is parametrised. Multiply latency is parametrised; divide is a 1-bit/cycle restoring iterative divider.
- Divide-by-zero and signed-overflow are short-circuited in one cycle.

Parameters:
- XLEN, 32, operand/result width.
- MUL_LAT, 2, edges from accept to o_valid for MUL* ops (>=1).
- TAG_W, 5, width of destination-register tag carried with the op.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  synchronous active-low reset.
- i_valid  in  1  request valid.
- o_ready  out  1  unit can accept (state IDLE).
- i_funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- i_rs1  in  XLEN  operand A (dividend).
- i_rs2  in  XLEN  operand B (divisor).
- i_rd  in  TAG_W  destination tag.
- i_flush  in  1  kill in-flight op (branch/jump redirect).
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts result.
- o_result  out  XLEN  rd value.
- o_rd  out  TAG_W  tag of the result.
- o_busy  out  1  state != IDLE, used by the hazard unit.

Behaviour:
- Reset:
  - Applies on any edge with i_rst_n=0. Overrides everything, including an op mid-divide.
  - State becomes IDLE. o_valid=0, o_result=0, o_rd=0, o_busy=0, o_ready=1 after that edge. Iteration counter=0.
- Accept:
  - Occurs when i_valid && o_ready && !i_flush at an edge.
  - Captures funct3, operands and rd.
  - If i_flush=1 in the same cycle, nothing is accepted.
- FSM states:
  - IDLE -> MUL on accept of funct3[2]=0.
  - IDLE -> DIV on accept of a normal divide.
  - IDLE -> DONE on accept of a special divide.
  - MUL -> DONE after MUL_LAT-1 further edges, so o_valid rises on edge MUL_LAT after accept.
  - DIV -> DONE after XLEN iterations, so o_valid rises on edge XLEN+1 after accept.
  - DONE -> IDLE on o_valid && i_ready.
- Multiply:
  - Operands are extended to XLEN+1 bits: signed for MULH and rs1 of MULHSU; zero-extended otherwise.
  - The full 2*XLEN product is formed.
  - MUL returns the low XLEN bits; the other multiply ops return the high XLEN bits.
  - The product may be registered internally across the MUL_LAT stages.
- Divide:
  - Signed ops divide magnitudes, then negate the quotient if the signs differ.
  - The remainder takes the dividend's sign.
  - Each iteration shifts one quotient bit in. The sign fix is applied on the final transition into DONE.
- Special divides (decided at accept, result on edge 1):
  - Divisor 0: DIV/DIVU = all ones; REM/REMU = dividend.
  - Signed overflow (rs1 = -2^(XLEN-1), rs2 = -1): DIV = rs1; REM = 0.
- Output hold:
  - In DONE, o_valid=1. o_result and o_rd stay stable until the edge where i_ready=1.
  - o_valid drops on that same edge. o_ready=1 in the following cycle, so there is no back-to-back accept in the handshake cycle.
- Flush:
  - i_flush=1 in any non-IDLE state returns to IDLE on that edge, including DONE with i_ready=0.
  - o_valid=0 and the result is discarded.
  - i_flush in IDLE has no effect other than blocking accept.
- o_ready = (state==IDLE). o_busy = !o_ready.
- Inputs are don't-care outside the accept cycle.

Test Plan:
- MULH with rs1=rs2=0x80000000, MUL_LAT=2 -> o_valid on edge 2, o_result=0x40000000. MUL with the same operands -> 0x00000000.
- MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF. MULHU with the same operands -> 0xFFFFFFFE. MUL -> 0x00000001.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD on edge 33. REM with the same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14, and REMU -> 2. o_busy is high edges 1-32.
- Special cases, each with o_valid on edge 1:
  - DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
- Backpressure: hold i_ready=0 for 3 cycles after o_valid with rd=7 -> o_result and o_rd=7 stable, o_ready=0, and a concurrent i_valid is not accepted. Raise i_ready -> o_valid=0 next edge.
- Flush and reset mid-divide:
  - i_flush at edge 10 of a DIV -> IDLE, o_valid never asserts. A following MUL 3x4 returns 12 normally.
  - Repeat with i_rst_n=0 instead of i_flush -> same outcome, and o_result=0.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M multiply/divide unit with a valid/ready handshake.
// Multiplies finish after MUL_LAT edges. Divides use a 1-bit/cycle restoring
// divider. Divide-by-zero and signed overflow finish on the accept edge.
module muldiv_unit #(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 2,
    parameter int TAG_W   = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_funct3,
    input  logic [XLEN-1:0]  i_rs1,
    input  logic [XLEN-1:0]  i_rs2,
    input  logic [TAG_W-1:0] i_rd,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [XLEN-1:0]  o_result,
    output logic [TAG_W-1:0] o_rd,
    output logic             o_busy
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    localparam int CNT_MAX = (XLEN > MUL_LAT) ? XLEN : MUL_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] MUL_CNT_INIT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT_INIT = CNT_W'(XLEN);
    localparam logic [XLEN-1:0]  INT_MIN      = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;            // funct3[1:0] of the op in flight
    logic [TAG_W-1:0]  rd_q, rd_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [XLEN-1:0]   dvs_q, dvs_d;          // divisor magnitude
    logic [XLEN-1:0]   quo_q, quo_d;          // dividend shifts out, quotient shifts in
    logic [XLEN-1:0]   rem_q, rem_d;          // partial remainder
    logic              quo_neg_q, quo_neg_d;
    logic              rem_neg_q, rem_neg_d;

    // Low-word select for MUL, high word for MULH/MULHSU/MULHU
    function automatic logic [XLEN-1:0] mul_sel(input logic [1:0] op, input logic [2*XLEN-1:0] p);
        return (op == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

    // Operand decode and extension; sign-extending to 2*XLEN gives the same low
    // 2*XLEN product bits as an (XLEN+1)-bit signed multiply.
    logic              mul_a_sgn, mul_b_sgn;
    logic [2*XLEN-1:0] mul_a, mul_b, mul_prod;
    logic              div_signed, div_zero, div_ovf;
    logic [XLEN-1:0]   rs1_mag, rs2_mag;
    logic [XLEN:0]     rem_diff;
    logic              q_bit;
    logic [XLEN-1:0]   rem_step, quo_step;
    logic              accept;

    assign mul_a_sgn  = (i_funct3[1:0] == 2'b01) || (i_funct3[1:0] == 2'b10);
    assign mul_b_sgn  = (i_funct3[1:0] == 2'b01);
    assign mul_a      = {{XLEN{mul_a_sgn & i_rs1[XLEN-1]}}, i_rs1};
    assign mul_b      = {{XLEN{mul_b_sgn & i_rs2[XLEN-1]}}, i_rs2};
    assign mul_prod   = mul_a * mul_b;

    assign div_signed = ~i_funct3[0];
    assign div_zero   = (i_rs2 == '0);
    assign div_ovf    = div_signed && (i_rs1 == INT_MIN) && (i_rs2 == '1);
    assign rs1_mag    = (div_signed && i_rs1[XLEN-1]) ? -i_rs1 : i_rs1;
    assign rs2_mag    = (div_signed && i_rs2[XLEN-1]) ? -i_rs2 : i_rs2;

    // One restoring step: shift in the next dividend bit, subtract if it fits
    assign rem_diff   = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};
    assign q_bit      = ~rem_diff[XLEN];
    assign rem_step   = q_bit ? rem_diff[XLEN-1:0] : {rem_q[XLEN-2:0], quo_q[XLEN-1]};
    assign quo_step   = {quo_q[XLEN-2:0], q_bit};

    assign accept     = i_valid && (state_q == S_IDLE) && !i_flush;
    assign o_ready    = (state_q == S_IDLE);
    assign o_busy     = !o_ready;
    assign o_valid    = (state_q == S_DONE);
    assign o_result   = result_q;
    assign o_rd       = rd_q;

    // Next-state logic: accept, multiply wait, divide iterations, handshake, flush
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rd_d      = rd_q;
        result_d  = result_q;
        cnt_d     = cnt_q;
        prod_d    = prod_q;
        dvs_d     = dvs_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d = i_funct3[1:0];
                    rd_d = i_rd;
                    if (!i_funct3[2]) begin
                        prod_d = mul_prod;
                        if (MUL_LAT <= 1) begin
                            state_d  = S_DONE;
                            result_d = mul_sel(i_funct3[1:0], mul_prod);
                        end else begin
                            state_d = S_MUL;
                            cnt_d   = MUL_CNT_INIT;
                        end
                    end else if (div_zero) begin
                        state_d  = S_DONE;
                        result_d = i_funct3[1] ? i_rs1 : '1;
                    end else if (div_ovf) begin
                        state_d  = S_DONE;
                        result_d = i_funct3[1] ? '0 : i_rs1;
                    end else begin
                        state_d   = S_DIV;
                        cnt_d     = DIV_CNT_INIT;
                        dvs_d     = rs2_mag;
                        quo_d     = rs1_mag;
                        rem_d     = '0;
                        quo_neg_d = div_signed && (i_rs1[XLEN-1] ^ i_rs2[XLEN-1]);
                        rem_neg_d = div_signed && i_rs1[XLEN-1];
                    end
                end
            end
            S_MUL: begin
                if (i_flush) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q <= 1) begin
                    state_d  = S_DONE;
                    cnt_d    = '0;
                    result_d = mul_sel(op_q, prod_q);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DIV: begin
                if (i_flush) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    quo_d = quo_step;
                    rem_d = rem_step;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == 1) begin
                        state_d  = S_DONE;
                        result_d = op_q[1] ? (rem_neg_q ? -rem_step : rem_step)
                                           : (quo_neg_q ? -quo_step : quo_step);
                    end
                end
            end
            S_DONE: begin
                if (i_flush || i_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            rd_q      <= '0;
            result_q  <= '0;
            cnt_q     <= '0;
            prod_q    <= '0;
            dvs_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            result_q  <= result_d;
            cnt_q     <= cnt_d;
            prod_q    <= prod_d;
            dvs_q     <= dvs_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed tests for muldiv_unit with hand-computed expectations.
module tb_muldiv_unit;

    localparam int XLEN    = 32;
    localparam int MUL_LAT = 2;
    localparam int TAG_W   = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             i_valid;
    logic             o_ready;
    logic [2:0]       funct3;
    logic [XLEN-1:0]  rs1;
    logic [XLEN-1:0]  rs2;
    logic [TAG_W-1:0] rd;
    logic             i_flush;
    logic             o_valid;
    logic             i_ready;
    logic [XLEN-1:0]  o_result;
    logic [TAG_W-1:0] o_rd;
    logic             o_busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
    } vec_t;

    muldiv_unit #(.XLEN(XLEN), .MUL_LAT(MUL_LAT), .TAG_W(TAG_W)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_funct3 (funct3),
        .i_rs1    (rs1),
        .i_rs2    (rs2),
        .i_rd     (rd),
        .i_flush  (i_flush),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result),
        .o_rd     (o_rd),
        .o_busy   (o_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for one edge; returns just after that accept edge (edge 1)
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] tag);
        i_valid = 1'b1;
        funct3  = f;
        rs1     = a;
        rs2     = b;
        rd      = tag;
        tick();
        i_valid = 1'b0;
        rs1     = '0;
        rs2     = '0;
    endtask

    task automatic consume();
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b0;
        funct3 = '0; rs1 = '0; rs2 = '0; rd = '0;
        tick(); tick();
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_o_valid: got %b expected 0", o_valid); end
        n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_o_ready: got %b expected 1", o_ready); end
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_o_busy: got %b expected 0", o_busy); end
        n_checks++; if (o_result !== 32'h0) begin n_fail++; $display("FAIL reset_o_result: got %h expected 00000000", o_result); end
        n_checks++; if (o_rd !== 5'd0) begin n_fail++; $display("FAIL reset_o_rd: got %0d expected 0", o_rd); end
        rst_n = 1'b1;
        tick();
        $display("reset done");
    endtask

    task automatic test_mul();
        vec_t v [6];
        int   edges;
        v[0] = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000};
        v[1] = '{3'b000, 32'h80000000, 32'h80000000, 32'h00000000};
        v[2] = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        v[3] = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        v[4] = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
        v[5] = '{3'b000, 32'd3,        32'd4,        32'd12};
        foreach (v[i]) begin
            issue(v[i].f, v[i].a, v[i].b, TAG_W'(i + 1));
            edges = 1;
            while (!o_valid && edges < 100) begin tick(); edges++; end
            n_checks++; if (edges !== MUL_LAT) begin n_fail++; $display("FAIL mul_latency[%0d]: got %0d expected %0d", i, edges, MUL_LAT); end
            n_checks++; if (o_result !== v[i].r) begin n_fail++; $display("FAIL mul_result[%0d]: got %h expected %h", i, o_result, v[i].r); end
            n_checks++; if (o_rd !== TAG_W'(i + 1)) begin n_fail++; $display("FAIL mul_rd[%0d]: got %0d expected %0d", i, o_rd, i + 1); end
            consume();
            n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL mul_valid_drop[%0d]: got %b expected 0", i, o_valid); end
            $display("mul f=%b a=%h b=%h -> %h at edge %0d", v[i].f, v[i].a, v[i].b, o_result, edges);
        end
    endtask

    task automatic test_div();
        vec_t v [4];
        int   edges;
        int   busy_bad;
        v[0] = '{3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD};
        v[1] = '{3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF};
        v[2] = '{3'b101, 32'd100,      32'd7, 32'd14};
        v[3] = '{3'b111, 32'd100,      32'd7, 32'd2};
        foreach (v[i]) begin
            issue(v[i].f, v[i].a, v[i].b, TAG_W'(10 + i));
            edges    = 1;
            busy_bad = 0;
            while (!o_valid && edges < 100) begin
                if (o_busy !== 1'b1) busy_bad++;
                tick();
                edges++;
            end
            n_checks++; if (edges !== XLEN + 1) begin n_fail++; $display("FAIL div_latency[%0d]: got %0d expected %0d", i, edges, XLEN + 1); end
            n_checks++; if (busy_bad !== 0) begin n_fail++; $display("FAIL div_busy[%0d]: got %0d low cycles expected 0", i, busy_bad); end
            n_checks++; if (o_result !== v[i].r) begin n_fail++; $display("FAIL div_result[%0d]: got %h expected %h", i, o_result, v[i].r); end
            n_checks++; if (o_rd !== TAG_W'(10 + i)) begin n_fail++; $display("FAIL div_rd[%0d]: got %0d expected %0d", i, o_rd, 10 + i); end
            consume();
            $display("div f=%b a=%h b=%h -> %h at edge %0d", v[i].f, v[i].a, v[i].b, o_result, edges);
        end
    endtask

    task automatic test_special();
        vec_t v [6];
        int   edges;
        v[0] = '{3'b101, 32'd5,        32'd0,        32'hFFFFFFFF};
        v[1] = '{3'b111, 32'd5,        32'd0,        32'd5};
        v[2] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
        v[3] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000};
        v[4] = '{3'b100, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF};
        v[5] = '{3'b110, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB};
        foreach (v[i]) begin
            issue(v[i].f, v[i].a, v[i].b, TAG_W'(20 + i));
            edges = 1;
            while (!o_valid && edges < 100) begin tick(); edges++; end
            n_checks++; if (edges !== 1) begin n_fail++; $display("FAIL special_latency[%0d]: got %0d expected 1", i, edges); end
            n_checks++; if (o_result !== v[i].r) begin n_fail++; $display("FAIL special_result[%0d]: got %h expected %h", i, o_result, v[i].r); end
            consume();
            $display("special f=%b a=%h b=%h -> %h at edge %0d", v[i].f, v[i].a, v[i].b, o_result, edges);
        end
    endtask

    task automatic test_backpressure();
        int edges;
        int valids;
        issue(3'b000, 32'd3, 32'd4, 5'd7);
        edges = 1;
        while (!o_valid && edges < 100) begin tick(); edges++; end
        n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b expected 1", o_valid); end
        // Competing request while the result is stalled must be ignored
        i_valid = 1'b1; funct3 = 3'b000; rs1 = 32'd5; rs2 = 32'd5; rd = 5'd3;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid[%0d]: got %b expected 1", k, o_valid); end
            n_checks++; if (o_result !== 32'd12) begin n_fail++; $display("FAIL bp_hold_result[%0d]: got %h expected 0000000c", k, o_result); end
            n_checks++; if (o_rd !== 5'd7) begin n_fail++; $display("FAIL bp_hold_rd[%0d]: got %0d expected 7", k, o_rd); end
            n_checks++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_ready[%0d]: got %b expected 0", k, o_ready); end
        end
        // Handshake edge with i_valid still high: no back-to-back accept
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        i_valid = 1'b0;
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b expected 0", o_valid); end
        n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 1", o_ready); end
        valids = 0;
        for (int k = 0; k < 5; k++) begin tick(); if (o_valid === 1'b1) valids++; end
        n_checks++; if (valids !== 0) begin n_fail++; $display("FAIL bp_no_phantom: got %0d valid cycles expected 0", valids); end
        $display("backpressure rd=7 result=%h released", o_result);
    endtask

    task automatic test_flush();
        int edges;
        int valids;
        // Flush on edge 10 of a divide
        issue(3'b101, 32'd100, 32'd7, 5'd4);
        for (int k = 0; k < 8; k++) tick();
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL flush_div_busy: got %b expected 0", o_busy); end
        n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL flush_div_ready: got %b expected 1", o_ready); end
        valids = 0;
        for (int k = 0; k < 40; k++) begin tick(); if (o_valid === 1'b1) valids++; end
        n_checks++; if (valids !== 0) begin n_fail++; $display("FAIL flush_div_no_valid: got %0d valid cycles expected 0", valids); end
        issue(3'b000, 32'd3, 32'd4, 5'd5);
        edges = 1;
        while (!o_valid && edges < 100) begin tick(); edges++; end
        n_checks++; if (edges !== MUL_LAT) begin n_fail++; $display("FAIL flush_mul_latency: got %0d expected %0d", edges, MUL_LAT); end
        n_checks++; if (o_result !== 32'd12) begin n_fail++; $display("FAIL flush_mul_result: got %h expected 0000000c", o_result); end
        // Flush while DONE and stalled discards the result
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL flush_done_valid: got %b expected 0", o_valid); end
        // Flush in IDLE blocks accept
        i_valid = 1'b1; i_flush = 1'b1; funct3 = 3'b000; rs1 = 32'd2; rs2 = 32'd2;
        tick();
        i_valid = 1'b0; i_flush = 1'b0;
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL flush_idle_block: got busy %b expected 0", o_busy); end
        $display("flush checks done");
    endtask

    task automatic test_reset_mid_div();
        int edges;
        int valids;
        issue(3'b100, 32'hFFFFFFF9, 32'd2, 5'd6);
        for (int k = 0; k < 8; k++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", o_busy); end
        n_checks++; if (o_result !== 32'h0) begin n_fail++; $display("FAIL rstmid_result: got %h expected 00000000", o_result); end
        n_checks++; if (o_rd !== 5'd0) begin n_fail++; $display("FAIL rstmid_rd: got %0d expected 0", o_rd); end
        valids = 0;
        for (int k = 0; k < 40; k++) begin tick(); if (o_valid === 1'b1) valids++; end
        n_checks++; if (valids !== 0) begin n_fail++; $display("FAIL rstmid_no_valid: got %0d valid cycles expected 0", valids); end
        issue(3'b000, 32'd3, 32'd4, 5'd9);
        edges = 1;
        while (!o_valid && edges < 100) begin tick(); edges++; end
        n_checks++; if (edges !== MUL_LAT) begin n_fail++; $display("FAIL rstmid_mul_latency: got %0d expected %0d", edges, MUL_LAT); end
        n_checks++; if (o_result !== 32'd12) begin n_fail++; $display("FAIL rstmid_mul_result: got %h expected 0000000c", o_result); end
        n_checks++; if (o_rd !== 5'd9) begin n_fail++; $display("FAIL rstmid_mul_rd: got %0d expected 9", o_rd); end
        consume();
        $display("reset mid-divide checks done");
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_backpressure();
        test_flush();
        test_reset_mid_div();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
